bin_morph3x3: RTL and testbench

//  Streaming 3x3 binary morphology (erode/dilate) on a 1-bit-per-pixel raster.

---
 rtl/morph_pkg.sv | 12 +
 rtl/dpram1.sv | 24 ++
 rtl/bin_morph3x3.sv | 153 +++++++++++++++
 tb/tb_bin_morph3x3.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// rtl/morph_pkg.sv - shared constants for the 3x3 binary morphology block
package morph_pkg;

    localparam logic MODE_ERODE  = 1'b0;
    localparam logic MODE_DILATE = 1'b1;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;
    localparam int DEF_COL_W = 10;
    localparam int DEF_ROW_W = 9;

endpackage

// File: rtl/dpram1.sv
// rtl/dpram1.sv - simple dual-port RAM, one write port, registered read port
module dpram1 #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 10
) (
    input  logic             clock,
    input  logic             wren,
    input  logic [DEPTH-1:0] wraddress,
    input  logic [WIDTH-1:0] data,
    input  logic [DEPTH-1:0] rdaddress,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [0:(2**DEPTH)-1];

    // Write when enabled; read is registered and returns old data on a same-address collision.
    always_ff @(posedge clock) begin
        if (wren) begin
            mem[wraddress] <= data;
        end
        q <= mem[rdaddress];
    end

endmodule

// File: rtl/bin_morph3x3.sv
// rtl/bin_morph3x3.sv - streaming 3x3 binary erode/dilate with two line buffers
module bin_morph3x3
    import morph_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int COL_W = DEF_COL_W,
    parameter int ROW_W = DEF_ROW_W
) (
    input  logic clock,
    input  logic rst_n,
    input  logic i_valid,
    input  logic i_pixel,
    input  logic i_sof,
    input  logic i_mode,
    output logic o_valid,
    output logic o_pixel,
    output logic o_sof,
    output logic o_eol,
    output logic o_eof
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    logic [COL_W-1:0] col, pix_col, s1_col;
    logic [ROW_W-1:0] row, pix_row, s1_row;
    logic             mode, pix_mode;
    logic             s1_valid, s1_pixel, s1_mode;
    logic             lb0_q, lb1_q;
    logic [2:0]       win_l, win_m, win_r;
    logic             s2_valid, s2_ok, s2_sof, s2_eol, s2_eof, s2_mode;
    logic             gate, result;

    // Position and mode of the pixel on the input this cycle; i_sof restarts at (0,0).
    always_comb begin
        pix_col  = i_sof ? '0 : col;
        pix_row  = i_sof ? '0 : row;
        pix_mode = i_sof ? i_mode : mode;
    end

    // Raster counters and frame mode advance only on accepted pixels.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            mode <= MODE_ERODE;
        end else if (i_valid) begin
            mode <= pix_mode;
            if (pix_col == COL_LAST) begin
                col <= '0;
                row <= (pix_row == ROW_LAST) ? '0 : pix_row + ROW_ONE;
            end else begin
                col <= pix_col + COL_ONE;
                row <= pix_row;
            end
        end
    end

    // Stage 1: capture the accepted pixel with its position; mode travels with it so a
    // new frame never changes the operator on the previous frame's tail.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pixel <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_mode  <= MODE_ERODE;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_pixel <= i_pixel;
                s1_col   <= pix_col;
                s1_row   <= pix_row;
                s1_mode  <= pix_mode;
            end
        end
    end

    // lb0 holds the previous row, lb1 the one before; the write trails the read by a cycle.
    dpram1 #(.WIDTH(1), .DEPTH(COL_W)) lb0 (
        .clock     (clock),
        .wren      (s1_valid),
        .wraddress (s1_col),
        .data      (s1_pixel),
        .rdaddress (pix_col),
        .q         (lb0_q)
    );

    dpram1 #(.WIDTH(1), .DEPTH(COL_W)) lb1 (
        .clock     (clock),
        .wren      (s1_valid),
        .wraddress (s1_col),
        .data      (lb0_q),
        .rdaddress (pix_col),
        .q         (lb1_q)
    );

    // Stage 2: shift the new column into the window and derive position flags.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_ok    <= 1'b0;
            s2_sof   <= 1'b0;
            s2_eol   <= 1'b0;
            s2_eof   <= 1'b0;
            s2_mode  <= MODE_ERODE;
            win_l    <= '0;
            win_m    <= '0;
            win_r    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                win_l   <= win_m;
                win_m   <= win_r;
                win_r   <= {lb1_q, lb0_q, s1_pixel};
                s2_ok   <= (s1_row >= ROW_TWO) && (s1_col >= COL_TWO);
                s2_sof  <= (s1_row == ROW_TWO) && (s1_col == COL_TWO);
                s2_eol  <= (s1_col == COL_LAST);
                s2_eof  <= (s1_row == ROW_LAST) && (s1_col == COL_LAST);
                s2_mode <= s1_mode;
            end
        end
    end

    // Only interior centres are emitted; everything else is suppressed to zero.
    always_comb begin
        gate   = s2_valid & s2_ok;
        result = (s2_mode == MODE_DILATE) ? |{win_l, win_m, win_r} : &{win_l, win_m, win_r};
    end

    // Stage 3: registered result and single-cycle strobes.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_pixel <= 1'b0;
            o_sof   <= 1'b0;
            o_eol   <= 1'b0;
            o_eof   <= 1'b0;
        end else begin
            o_valid <= gate;
            o_pixel <= gate & result;
            o_sof   <= gate & s2_sof;
            o_eol   <= gate & s2_eol;
            o_eof   <= gate & s2_eof;
        end
    end

endmodule

// File: tb/tb_bin_morph3x3.sv
// tb/tb_bin_morph3x3.sv - directed self-checking bench for bin_morph3x3
module tb_bin_morph3x3;
    import morph_pkg::*;

    localparam int IMG_W = 6;
    localparam int IMG_H = 5;
    localparam int LAST_IDX = IMG_W * IMG_H - 1;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic i_valid = 1'b0, i_pixel = 1'b0, i_sof = 1'b0, i_mode = 1'b0;
    logic o_valid, o_pixel, o_sof, o_eol, o_eof;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sof_cyc  = -1;
    int in22_cyc = -1;
    bit q_pix[$], q_sof[$], q_eol[$], q_eof[$];

    bin_morph3x3 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .COL_W(3), .ROW_W(3)) dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_pixel (i_pixel),
        .i_sof   (i_sof),
        .i_mode  (i_mode),
        .o_valid (o_valid),
        .o_pixel (o_pixel),
        .o_sof   (o_sof),
        .o_eol   (o_eol),
        .o_eof   (o_eof)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (o_valid) begin
            q_pix.push_back(o_pixel);
            q_sof.push_back(o_sof);
            q_eol.push_back(o_eol);
            q_eof.push_back(o_eof);
            if (o_sof) sof_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "timeout");
    end

    function automatic logic [11:0] pack_q(input bit q[$]);
        logic [11:0] v = '0;
        for (int i = 0; i < q.size() && i < 12; i++) v[i] = q[i];
        return v;
    endfunction

    function automatic logic pix_of(input int kind, input int r, input int c);
        if (kind == 0) return 1'b1;
        return (r == 2 && c == 2);
    endfunction

    task automatic clear_q();
        q_pix.delete();
        q_sof.delete();
        q_eol.delete();
        q_eof.delete();
        sof_cyc = -1;
        in22_cyc = -1;
    endtask

    task automatic drain();
        @(negedge clock);
        i_valid = 1'b0;
        i_sof   = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic send_range(input int kind, input logic mode, input int gap,
                              input int lo, input int hi, input bit use_sof);
        for (int idx = lo; idx <= hi; idx++) begin
            int idles = 0;
            while (gap > 0 && idles < 4 && $urandom_range(99) < gap) begin
                @(negedge clock);
                i_valid = 1'b0;
                i_sof   = 1'($urandom_range(1));
                i_pixel = 1'($urandom_range(1));
                i_mode  = ~mode;
                idles++;
            end
            @(negedge clock);
            i_valid = 1'b1;
            i_sof   = (idx == lo) && use_sof;
            i_pixel = pix_of(kind, idx / IMG_W, idx % IMG_W);
            i_mode  = (idx == lo) ? mode : ~mode;
            if (idx == 14) in22_cyc = cyc;
        end
        drain();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({o_valid, o_pixel, o_sof, o_eol, o_eof} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 00000", {o_valid, o_pixel, o_sof, o_eol, o_eof});
        end
        rst_n = 1'b1;
        clear_q();
        send_range(0, MODE_ERODE, 0, 0, LAST_IDX, 1'b0);
        n_checks++;
        if (q_pix.size() !== 12) begin
            n_fail++;
            $display("FAIL reset_nosof_count got %0d want 12", q_pix.size());
        end
        n_checks++;
        if (pack_q(q_pix) !== 12'hFFF) begin
            n_fail++;
            $display("FAIL reset_nosof_pix got %h want fff", pack_q(q_pix));
        end
    endtask

    task automatic test_erode_ones(input int gap);
        clear_q();
        send_range(0, MODE_ERODE, gap, 0, LAST_IDX, 1'b1);
        n_checks++;
        if (q_pix.size() !== 12) begin
            n_fail++;
            $display("FAIL erode_ones_count gap=%0d got %0d want 12", gap, q_pix.size());
        end
        n_checks++;
        if (pack_q(q_pix) !== 12'hFFF) begin
            n_fail++;
            $display("FAIL erode_ones_pix gap=%0d got %h want fff", gap, pack_q(q_pix));
        end
        n_checks++;
        if ({pack_q(q_sof), pack_q(q_eol), pack_q(q_eof)} !== {12'h001, 12'h888, 12'h800}) begin
            n_fail++;
            $display("FAIL erode_ones_flags gap=%0d got sof=%h eol=%h eof=%h want 001 888 800",
                     gap, pack_q(q_sof), pack_q(q_eol), pack_q(q_eof));
        end
    endtask

    task automatic test_single(input int gap);
        clear_q();
        send_range(1, MODE_DILATE, gap, 0, LAST_IDX, 1'b1);
        n_checks++;
        if (q_pix.size() !== 12) begin
            n_fail++;
            $display("FAIL dilate_single_count gap=%0d got %0d want 12", gap, q_pix.size());
        end
        n_checks++;
        if (pack_q(q_pix) !== 12'h777) begin
            n_fail++;
            $display("FAIL dilate_single_pix gap=%0d got %h want 777", gap, pack_q(q_pix));
        end
        clear_q();
        send_range(1, MODE_ERODE, gap, 0, LAST_IDX, 1'b1);
        n_checks++;
        if (q_pix.size() !== 12) begin
            n_fail++;
            $display("FAIL erode_single_count gap=%0d got %0d want 12", gap, q_pix.size());
        end
        n_checks++;
        if (pack_q(q_pix) !== 12'h000) begin
            n_fail++;
            $display("FAIL erode_single_pix gap=%0d got %h want 000", gap, pack_q(q_pix));
        end
    endtask

    task automatic test_mid_sof();
        clear_q();
        send_range(0, MODE_ERODE, 0, 0, 3 * IMG_W, 1'b1);
        n_checks++;
        if (q_pix.size() !== 4) begin
            n_fail++;
            $display("FAIL mid_sof_partial_count got %0d want 4", q_pix.size());
        end
        clear_q();
        send_range(1, MODE_DILATE, 0, 0, LAST_IDX, 1'b1);
        n_checks++;
        if (q_pix.size() !== 12) begin
            n_fail++;
            $display("FAIL mid_sof_count got %0d want 12", q_pix.size());
        end
        n_checks++;
        if ({pack_q(q_pix), pack_q(q_sof)} !== {12'h777, 12'h001}) begin
            n_fail++;
            $display("FAIL mid_sof_pix_sof got %h/%h want 777/001", pack_q(q_pix), pack_q(q_sof));
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        clear_q();
        for (int idx = 0; idx <= LAST_IDX && !seen; idx++) begin
            @(negedge clock);
            if (o_valid) begin
                seen = 1'b1;
            end else begin
                i_valid = 1'b1;
                i_sof   = (idx == 0);
                i_pixel = 1'b1;
                i_mode  = MODE_ERODE;
            end
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_precondition got o_valid seen=%0d want 1", seen);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_pixel, o_sof, o_eol, o_eof} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got %b want 00000", {o_valid, o_pixel, o_sof, o_eol, o_eof});
        end
        i_valid = 1'b0;
        i_sof   = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        clear_q();
        send_range(1, MODE_DILATE, 0, 0, LAST_IDX, 1'b1);
        n_checks++;
        if (q_pix.size() !== 12) begin
            n_fail++;
            $display("FAIL reset_mid_count got %0d want 12", q_pix.size());
        end
        n_checks++;
        if (pack_q(q_pix) !== 12'h777) begin
            n_fail++;
            $display("FAIL reset_mid_pix got %h want 777", pack_q(q_pix));
        end
    endtask

    task automatic test_latency();
        clear_q();
        send_range(1, MODE_DILATE, 0, 0, LAST_IDX, 1'b1);
        n_checks++;
        if (sof_cyc - in22_cyc !== 3) begin
            n_fail++;
            $display("FAIL latency got %0d want 3 (in=%0d out=%0d)", sof_cyc - in22_cyc, in22_cyc, sof_cyc);
        end
        n_checks++;
        if (pack_q(q_pix) !== 12'h777) begin
            n_fail++;
            $display("FAIL latency_mode_hold got %h want 777", pack_q(q_pix));
        end
    endtask

    initial begin
        test_reset();
        test_erode_ones(0);
        test_single(0);
        test_erode_ones(40);
        test_single(40);
        test_mid_sof();
        test_reset_mid();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
